traffic_phase_ctrl: RTL and testbench

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_pkg.sv | 18 +
 rtl/rr_next_dir.sv | 41 ++++
 rtl/traffic_phase_ctrl.sv | 148 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encodings and per-approach lamp codes for the traffic phase controller.
package traffic_pkg;

    // Controller phase, also exported on the phase output.
    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2,
        PH_EMERG   = 2'd3
    } phase_e;

    // Lamp code per approach, packed as {red, yellow, green}.
    localparam int unsigned LIGHT_W      = 3;
    localparam logic [2:0]  LIGHT_RED    = 3'b100;
    localparam logic [2:0]  LIGHT_YELLOW = 3'b010;
    localparam logic [2:0]  LIGHT_GREEN  = 3'b001;

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin selection of the next approach to receive green, with optional
// skipping of approaches that have no vehicle waiting.
module rr_next_dir #(
    parameter int unsigned NUM_DIR = 4,
    parameter int unsigned DIR_W   = $clog2(NUM_DIR)
) (
    input  logic [DIR_W-1:0]   active_dir,
    input  logic [NUM_DIR-1:0] veh_req,
    input  logic               skip_en,
    output logic [DIR_W-1:0]   next_dir
);

    logic [DIR_W-1:0] plain_dir;
    logic [DIR_W-1:0] cand_dir;
    int unsigned      cand_idx;
    logic             found;

    // Scan from active_dir+1 (wrapping) for the first requesting approach;
    // with no requests anywhere, fall back to plain round-robin.
    always_comb begin
        plain_dir = '0;
        cand_dir  = '0;
        cand_idx  = 0;
        found     = 1'b0;
        if (active_dir != DIR_W'(NUM_DIR - 1)) begin
            plain_dir = active_dir + 1'b1;
        end
        next_dir = plain_dir;
        if (skip_en) begin
            for (int unsigned i = 0; i < NUM_DIR; i++) begin
                cand_idx = (32'(active_dir) + 32'd1 + i) % NUM_DIR;
                cand_dir = DIR_W'(cand_idx);
                if (!found && veh_req[cand_dir]) begin
                    next_dir = cand_dir;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic intersection phase controller: round-robin green/yellow/all-red
// sequencing with optional demand skipping and emergency preemption.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_DIR = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [CNT_W-1:0]              green_time,
    input  logic [CNT_W-1:0]              yellow_time,
    input  logic [CNT_W-1:0]              allred_time,
    input  logic                          skip_en,
    input  logic [NUM_DIR-1:0]            veh_req,
    input  logic                          emerg_req,
    input  logic [$clog2(NUM_DIR)-1:0]    emerg_dir,
    output logic [LIGHT_W*NUM_DIR-1:0]    lights,
    output logic [$clog2(NUM_DIR)-1:0]    active_dir,
    output logic [1:0]                    phase
);

    localparam int unsigned DIR_W    = $clog2(NUM_DIR);
    localparam int unsigned LIGHTS_W = LIGHT_W * NUM_DIR;

    phase_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic [LIGHTS_W-1:0] lights_q, lights_d;
    logic [DIR_W-1:0]    rr_dir;
    logic [DIR_W-1:0]    emerg_dir_eff;

    // Counter preload for a phase of the given length; zero length runs one cycle.
    function automatic logic [CNT_W-1:0] load_cnt(input logic [CNT_W-1:0] dur);
        return (dur == '0) ? '0 : dur - 1'b1;
    endfunction

    // Out-of-range emergency approach folds to approach 0.
    generate
        if ((1 << DIR_W) == NUM_DIR) begin : gen_emerg_full
            assign emerg_dir_eff = emerg_dir;
        end else begin : gen_emerg_clamp
            assign emerg_dir_eff = (emerg_dir >= DIR_W'(NUM_DIR)) ? '0 : emerg_dir;
        end
    endgenerate

    // Next approach for normal service after an all-red clearance.
    rr_next_dir #(
        .NUM_DIR (NUM_DIR),
        .DIR_W   (DIR_W)
    ) u_rr_next_dir (
        .active_dir (dir_q),
        .veh_req    (veh_req),
        .skip_en    (skip_en),
        .next_dir   (rr_dir)
    );

    // State, counter, owner and lamp registers; reset lands in a 1-cycle all-red.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PH_ALL_RED;
            cnt_q    <= '0;
            dir_q    <= DIR_W'(NUM_DIR - 1);
            lights_q <= {NUM_DIR{LIGHT_RED}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            lights_q <= lights_d;
        end
    end

    // Phase sequencing; everything holds while en is low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (en) begin
            case (state_q)
                PH_ALL_RED: begin
                    if (cnt_q == '0) begin
                        if (emerg_req) begin
                            state_d = PH_EMERG;
                            dir_d   = emerg_dir_eff;
                        end else begin
                            state_d = PH_GREEN;
                            dir_d   = rr_dir;
                            cnt_d   = load_cnt(green_time);
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                PH_GREEN: begin
                    if (emerg_req && (dir_q == emerg_dir_eff)) begin
                        // Already serving the emergency approach: keep green, no yellow.
                        state_d = PH_EMERG;
                    end else if (emerg_req || (cnt_q == '0)) begin
                        state_d = PH_YELLOW;
                        cnt_d   = load_cnt(yellow_time);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (cnt_q == '0) begin
                        state_d = PH_ALL_RED;
                        cnt_d   = load_cnt(allred_time);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                PH_EMERG: begin
                    // Owner is latched on entry, so emerg_dir is not looked at here.
                    if (!emerg_req) begin
                        state_d = PH_YELLOW;
                        cnt_d   = load_cnt(yellow_time);
                    end
                end
                default: begin
                    state_d = PH_ALL_RED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Lamp pattern for the upcoming state, registered alongside it.
    always_comb begin
        lights_d = {NUM_DIR{LIGHT_RED}};
        for (int unsigned i = 0; i < NUM_DIR; i++) begin
            if (DIR_W'(i) == dir_d) begin
                case (state_d)
                    PH_GREEN,
                    PH_EMERG:  lights_d[LIGHT_W*i +: LIGHT_W] = LIGHT_GREEN;
                    PH_YELLOW: lights_d[LIGHT_W*i +: LIGHT_W] = LIGHT_YELLOW;
                    default:   lights_d[LIGHT_W*i +: LIGHT_W] = LIGHT_RED;
                endcase
            end
        end
    end

    assign lights     = lights_q;
    assign active_dir = dir_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed self-checking bench for traffic_phase_ctrl (NUM_DIR=4, CNT_W=8).
module tb_traffic_phase_ctrl;

    localparam logic [11:0] L_ALL_RED = 12'h924;
    localparam logic [11:0] L_G0      = 12'h921;
    localparam logic [11:0] L_Y0      = 12'h922;
    localparam logic [11:0] L_G2      = 12'h864;
    localparam logic [11:0] L_G3      = 12'h324;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  green_time;
    logic [7:0]  yellow_time;
    logic [7:0]  allred_time;
    logic        skip_en;
    logic [3:0]  veh_req;
    logic        emerg_req;
    logic [1:0]  emerg_dir;
    logic [11:0] lights;
    logic [1:0]  active_dir;
    logic [1:0]  phase;

    int tests = 0;
    int fails = 0;

    traffic_phase_ctrl #(.NUM_DIR(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .green_time  (green_time),
        .yellow_time (yellow_time),
        .allred_time (allred_time),
        .skip_en     (skip_en),
        .veh_req     (veh_req),
        .emerg_req   (emerg_req),
        .emerg_dir   (emerg_dir),
        .lights      (lights),
        .active_dir  (active_dir),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    // Count how many cycles the current (phase, dir) pair persists; returns on
    // the first cycle of the following pair, bounded at 200 cycles.
    task automatic measure(output logic [1:0] ph, output logic [1:0] d, output int n);
        ph = phase;
        d  = active_dir;
        n  = 1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (phase !== ph || active_dir !== d) break;
            n++;
        end
    endtask

    // From the first yellow cycle, run through yellow and all-red and measure the next green.
    task automatic go_green(output logic [1:0] ph, output logic [1:0] d, output int n);
        logic [1:0] p0, d0;
        int         n0;
        measure(p0, d0, n0);
        measure(p0, d0, n0);
        measure(ph, d, n);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (phase !== 2'd0) begin fails++; $display("FAIL reset_phase got %0d want 0", phase); end
        tests++; if (active_dir !== 2'd3) begin fails++; $display("FAIL reset_dir got %0d want 3", active_dir); end
        tests++; if (lights !== L_ALL_RED) begin fails++; $display("FAIL reset_lights got %h want %h", lights, L_ALL_RED); end
        @(posedge clk); #1;
        tests++; if (lights !== L_ALL_RED) begin fails++; $display("FAIL reset_hold_lights got %h want %h", lights, L_ALL_RED); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] ph, d;
        int         n;
        @(posedge clk); #1;
        tests++; if (phase !== 2'd1 || active_dir !== 2'd0) begin fails++; $display("FAIL rr_first_green got ph=%0d dir=%0d want ph=1 dir=0", phase, active_dir); end
        tests++; if (lights !== L_G0) begin fails++; $display("FAIL rr_first_lights got %h want %h", lights, L_G0); end
        for (int i = 0; i < 5; i++) begin
            measure(ph, d, n);
            tests++; if (ph !== 2'd1 || d !== 2'(i % 4) || n != 8) begin fails++; $display("FAIL rr_green%0d got ph=%0d dir=%0d len=%0d want ph=1 dir=%0d len=8", i, ph, d, n, i % 4); end
            if (i == 0) begin
                tests++; if (lights !== L_Y0) begin fails++; $display("FAIL rr_yellow_lights got %h want %h", lights, L_Y0); end
            end
            if (i < 4) begin
                measure(ph, d, n);
                tests++; if (ph !== 2'd2 || d !== 2'(i % 4) || n != 4) begin fails++; $display("FAIL rr_yellow%0d got ph=%0d dir=%0d len=%0d want ph=2 len=4", i, ph, d, n); end
                measure(ph, d, n);
                tests++; if (ph !== 2'd0 || n != 2) begin fails++; $display("FAIL rr_allred%0d got ph=%0d len=%0d want ph=0 len=2", i, ph, n); end
                if (i == 0) begin
                    tests++; if (lights !== 12'h90c) begin fails++; $display("FAIL rr_g1_lights got %h want 90c", lights); end
                end
            end
        end
    endtask

    task automatic test_skip();
        logic [1:0] ph, d;
        int         n;
        skip_en = 1'b1;
        veh_req = 4'b1000;
        go_green(ph, d, n);
        tests++; if (ph !== 2'd1 || d !== 2'd3 || n != 8) begin fails++; $display("FAIL skip_to3 got ph=%0d dir=%0d len=%0d want ph=1 dir=3 len=8", ph, d, n); end
        veh_req = 4'b0000;
        go_green(ph, d, n);
        tests++; if (d !== 2'd0) begin fails++; $display("FAIL skip_none_wrap got dir=%0d want 0", d); end
        go_green(ph, d, n);
        tests++; if (d !== 2'd1) begin fails++; $display("FAIL skip_none got dir=%0d want 1", d); end
        veh_req = 4'b0001;
        go_green(ph, d, n);
        tests++; if (d !== 2'd0) begin fails++; $display("FAIL skip_wrap_to0 got dir=%0d want 0", d); end
        skip_en = 1'b0;
        veh_req = 4'b0000;
    endtask

    task automatic test_emerg_preempt();
        logic [1:0] ph, d;
        int         n;
        apply_reset();
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (phase !== 2'd1 || active_dir !== 2'd0) begin fails++; $display("FAIL emerg_setup got ph=%0d dir=%0d want ph=1 dir=0", phase, active_dir); end
        emerg_req = 1'b1;
        emerg_dir = 2'd2;
        measure(ph, d, n);
        tests++; if (n != 1) begin fails++; $display("FAIL emerg_cut_green got len=%0d want 1", n); end
        measure(ph, d, n);
        tests++; if (ph !== 2'd2 || d !== 2'd0 || n != 4) begin fails++; $display("FAIL emerg_yellow got ph=%0d dir=%0d len=%0d want ph=2 dir=0 len=4", ph, d, n); end
        measure(ph, d, n);
        tests++; if (ph !== 2'd0 || n != 2) begin fails++; $display("FAIL emerg_allred got ph=%0d len=%0d want ph=0 len=2", ph, n); end
        tests++; if (phase !== 2'd3 || active_dir !== 2'd2 || lights !== L_G2) begin fails++; $display("FAIL emerg_enter got ph=%0d dir=%0d lights=%h want ph=3 dir=2 lights=%h", phase, active_dir, lights, L_G2); end
        emerg_dir = 2'd1;
        repeat (10) @(posedge clk);
        #1;
        tests++; if (phase !== 2'd3 || active_dir !== 2'd2 || lights !== L_G2) begin fails++; $display("FAIL emerg_hold got ph=%0d dir=%0d lights=%h want ph=3 dir=2 lights=%h", phase, active_dir, lights, L_G2); end
        emerg_req = 1'b0;
        measure(ph, d, n);
        tests++; if (ph !== 2'd3 || n != 1) begin fails++; $display("FAIL emerg_release got ph=%0d len=%0d want ph=3 len=1", ph, n); end
        measure(ph, d, n);
        tests++; if (ph !== 2'd2 || d !== 2'd2 || n != 4) begin fails++; $display("FAIL emerg_exit_yellow got ph=%0d dir=%0d len=%0d want ph=2 dir=2 len=4", ph, d, n); end
        measure(ph, d, n);
        tests++; if (ph !== 2'd0 || n != 2) begin fails++; $display("FAIL emerg_exit_allred got ph=%0d len=%0d want ph=0 len=2", ph, n); end
        tests++; if (phase !== 2'd1 || active_dir !== 2'd3) begin fails++; $display("FAIL emerg_resume got ph=%0d dir=%0d want ph=1 dir=3", phase, active_dir); end
    endtask

    task automatic test_emerg_same();
        logic [1:0] ph, d;
        int         n;
        tests++; if (lights !== L_G3) begin fails++; $display("FAIL same_pre_lights got %h want %h", lights, L_G3); end
        emerg_req = 1'b1;
        emerg_dir = 2'd3;
        @(posedge clk); #1;
        tests++; if (phase !== 2'd3 || active_dir !== 2'd3 || lights !== L_G3) begin fails++; $display("FAIL same_enter got ph=%0d dir=%0d lights=%h want ph=3 dir=3 lights=%h", phase, active_dir, lights, L_G3); end
        repeat (3) @(posedge clk);
        #1;
        emerg_req = 1'b0;
        @(posedge clk); #1;
        tests++; if (phase !== 2'd2 || active_dir !== 2'd3) begin fails++; $display("FAIL same_exit got ph=%0d dir=%0d want ph=2 dir=3", phase, active_dir); end
        measure(ph, d, n);
        tests++; if (n != 4) begin fails++; $display("FAIL same_yellow_len got %0d want 4", n); end
        measure(ph, d, n);
        tests++; if (ph !== 2'd0 || n != 2) begin fails++; $display("FAIL same_allred got ph=%0d len=%0d want ph=0 len=2", ph, n); end
        tests++; if (phase !== 2'd1 || active_dir !== 2'd0) begin fails++; $display("FAIL same_resume got ph=%0d dir=%0d want ph=1 dir=0", phase, active_dir); end
        emerg_dir = 2'd0;
    endtask

    task automatic test_timing();
        logic [1:0] ph, d;
        int         n;
        green_time = 8'd0;
        measure(ph, d, n);
        tests++; if (d !== 2'd0 || n != 8) begin fails++; $display("FAIL tim_midchange got dir=%0d len=%0d want dir=0 len=8", d, n); end
        go_green(ph, d, n);
        tests++; if (d !== 2'd1 || n != 1) begin fails++; $display("FAIL tim_green0 got dir=%0d len=%0d want dir=1 len=1", d, n); end
        green_time = 8'd3;
        go_green(ph, d, n);
        tests++; if (d !== 2'd2 || n != 3) begin fails++; $display("FAIL tim_green3 got dir=%0d len=%0d want dir=2 len=3", d, n); end
        yellow_time = 8'd0;
        allred_time = 8'd0;
        measure(ph, d, n);
        tests++; if (ph !== 2'd2 || n != 4) begin fails++; $display("FAIL tim_yellow_kept got ph=%0d len=%0d want ph=2 len=4", ph, n); end
        measure(ph, d, n);
        tests++; if (ph !== 2'd0 || n != 1) begin fails++; $display("FAIL tim_allred0 got ph=%0d len=%0d want ph=0 len=1", ph, n); end
        measure(ph, d, n);
        tests++; if (d !== 2'd3 || n != 3) begin fails++; $display("FAIL tim_green3b got dir=%0d len=%0d want dir=3 len=3", d, n); end
        measure(ph, d, n);
        tests++; if (ph !== 2'd2 || n != 1) begin fails++; $display("FAIL tim_yellow0 got ph=%0d len=%0d want ph=2 len=1", ph, n); end
        measure(ph, d, n);
        tests++; if (ph !== 2'd0 || n != 1) begin fails++; $display("FAIL tim_allred0b got ph=%0d len=%0d want ph=0 len=1", ph, n); end
    endtask

    task automatic test_enable();
        logic [1:0] ph, d;
        int         n;
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++; if (phase !== 2'd1 || active_dir !== 2'd0) begin fails++; $display("FAIL en_freeze got ph=%0d dir=%0d want ph=1 dir=0", phase, active_dir); end
        en = 1'b1;
        measure(ph, d, n);
        tests++; if (n != 3) begin fails++; $display("FAIL en_resume_len got %0d want 3", n); end
        green_time  = 8'd8;
        yellow_time = 8'd4;
        allred_time = 8'd2;
    endtask

    task automatic test_reset_mid_emerg();
        emerg_req = 1'b1;
        emerg_dir = 2'd1;
        for (int k = 0; k < 40; k++) begin
            if (phase === 2'd3) break;
            @(posedge clk); #1;
        end
        tests++; if (phase !== 2'd3 || active_dir !== 2'd1) begin fails++; $display("FAIL rstem_enter got ph=%0d dir=%0d want ph=3 dir=1", phase, active_dir); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (lights !== L_ALL_RED || phase !== 2'd0 || active_dir !== 2'd3) begin fails++; $display("FAIL rstem_async got lights=%h ph=%0d dir=%0d want lights=%h ph=0 dir=3", lights, phase, active_dir, L_ALL_RED); end
        emerg_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (phase !== 2'd1 || active_dir !== 2'd0 || lights !== L_G0) begin fails++; $display("FAIL rstem_first_green got ph=%0d dir=%0d lights=%h want ph=1 dir=0 lights=%h", phase, active_dir, lights, L_G0); end
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b1;
        green_time  = 8'd8;
        yellow_time = 8'd4;
        allred_time = 8'd2;
        skip_en     = 1'b0;
        veh_req     = 4'b0000;
        emerg_req   = 1'b0;
        emerg_dir   = 2'd0;
        test_reset();
        test_round_robin();
        test_skip();
        test_emerg_preempt();
        test_emerg_same();
        test_timing();
        test_enable();
        test_reset_mid_emerg();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
